// File: rtl/regfile_mp_if.sv
// Register-file port bundle: read addresses/data, two write ports, issue scoreboard
// inputs and the architectural a0/a1/a7 taps.
interface regfile_mp_if #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2
);
    logic [NUM_READ*ADDRESS_WIDTH-1:0] AD;
    logic [NUM_READ*DATA_WIDTH-1:0]    RD;
    logic [NUM_READ-1:0]               RD_busy;

    logic                     WE3;
    logic [ADDRESS_WIDTH-1:0] AD3;
    logic [DATA_WIDTH-1:0]    WD3;

    logic                     WE4;
    logic [ADDRESS_WIDTH-1:0] AD4;
    logic [DATA_WIDTH-1:0]    WD4;

    logic                     issue_valid;
    logic [ADDRESS_WIDTH-1:0] issue_rd;

    logic [DATA_WIDTH-1:0]    a0;
    logic [DATA_WIDTH-1:0]    a1;
    logic [DATA_WIDTH-1:0]    a7;

    // Decode/writeback side drives requests and observes results.
    modport master (
        output AD, WE3, AD3, WD3, WE4, AD4, WD4, issue_valid, issue_rd,
        input  RD, RD_busy, a0, a1, a7
    );

    // Register file side.
    modport slave (
        input  AD, WE3, AD3, WD3, WE4, AD4, WD4, issue_valid, issue_rd,
        output RD, RD_busy, a0, a1, a7
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file with two write ports and a per-register busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-to-read forwarding.
module regfile_mp #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    regfile_mp_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDRESS_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < DEPTH; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int unsigned r = 1; r < DEPTH; r++) begin
                if (bus.WE4 && bus.AD4 == ADDRESS_WIDTH'(r)) begin
                    regs[r] <= bus.WD4;
                end else if (bus.WE3 && bus.AD3 == ADDRESS_WIDTH'(r)) begin
                    regs[r] <= bus.WD3;
                end

                // A new producer issued this cycle outranks a retiring older write.
                if (bus.issue_valid && bus.issue_rd == ADDRESS_WIDTH'(r)) begin
                    busy[r] <= 1'b1;
                end else if ((bus.WE3 && bus.AD3 == ADDRESS_WIDTH'(r)) ||
                             (bus.WE4 && bus.AD4 == ADDRESS_WIDTH'(r))) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_READ; g++) begin : g_read
        logic [ADDRESS_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0]    data;
        logic                     bsy;

        assign addr = bus.AD[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];

        always_comb begin
            data = regs[addr];
            bsy  = busy[addr];
`ifdef REGFILE_BYPASS_EN
            if (bus.WE4 && bus.AD4 == addr) begin
                data = bus.WD4;
                bsy  = bus.issue_valid && bus.issue_rd == addr;
            end else if (bus.WE3 && bus.AD3 == addr) begin
                data = bus.WD3;
                bsy  = bus.issue_valid && bus.issue_rd == addr;
            end
`endif
            if (addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end
        end

        assign bus.RD[g*DATA_WIDTH +: DATA_WIDTH] = data;
        assign bus.RD_busy[g]                     = bsy;
    end

    // Architectural taps come straight from storage, never forwarded.
    assign bus.a0 = regs[10];
    assign bus.a1 = regs[11];
    assign bus.a7 = regs[17];
endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp with four read ports.
module tb_regfile_mp;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 4;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    logic [DW-1:0] exp_d;

    regfile_mp_if #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) bus ();

    regfile_mp #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish before 100000");
        $fatal(1);
    end

    function automatic logic [DW-1:0] rd(input int p);
        return bus.RD[p*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.WE3 = 1'b0;
        bus.AD3 = '0;
        bus.WD3 = '0;
        bus.WE4 = 1'b0;
        bus.AD4 = '0;
        bus.WD4 = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd = '0;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        bus.AD[p*AW +: AW] = a;
    endtask

    task automatic test_reset();
        bus.WE3 = 1'b1; bus.AD3 = 5'd5;  bus.WD3 = 32'h1234;
        bus.WE4 = 1'b1; bus.AD4 = 5'd10; bus.WD4 = 32'hA0A0;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        set_rd(0, 5'd5);
        tick();
        idle();
        checks++; if (rd(0) !== 32'h1234) begin errors++; $display("FAIL reset_pre_x5: got %h expected %h", rd(0), 32'h1234); end
        checks++; if (bus.a0 !== 32'hA0A0) begin errors++; $display("FAIL reset_pre_a0: got %h expected %h", bus.a0, 32'hA0A0); end
        checks++; if (bus.RD_busy[0] !== 1'b1) begin errors++; $display("FAIL reset_pre_busy: got %b expected 1", bus.RD_busy[0]); end

        rst_n = 1'b0;
        #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL reset_async_x5: got %h expected 0", rd(0)); end
        checks++; if (bus.RD_busy[0] !== 1'b0) begin errors++; $display("FAIL reset_async_busy: got %b expected 0", bus.RD_busy[0]); end
        checks++; if (bus.a0 !== 32'h0) begin errors++; $display("FAIL reset_async_a0: got %h expected 0", bus.a0); end
        checks++; if (bus.a1 !== 32'h0) begin errors++; $display("FAIL reset_async_a1: got %h expected 0", bus.a1); end
        checks++; if (bus.a7 !== 32'h0) begin errors++; $display("FAIL reset_async_a7: got %h expected 0", bus.a7); end
        rst_n = 1'b1;

        // write attempted while reset is held across the edge
        #1;
        bus.WE3 = 1'b1; bus.AD3 = 5'd6; bus.WD3 = 32'hABC;
        set_rd(1, 5'd6);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        idle();
        checks++; if (rd(1) !== 32'h0) begin errors++; $display("FAIL reset_midwrite: got %h expected 0", rd(1)); end
        tick();
        checks++; if (rd(1) !== 32'h0) begin errors++; $display("FAIL reset_midwrite_after: got %h expected 0", rd(1)); end
    endtask

    task automatic test_x0();
        bus.WE3 = 1'b1; bus.AD3 = 5'd0; bus.WD3 = 32'hDEADBEEF;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        set_rd(0, 5'd0);
        #1;
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_same_cycle: got %h expected 0", rd(0)); end
        tick();
        idle();
        checks++; if (rd(0) !== 32'h0) begin errors++; $display("FAIL x0_data: got %h expected 0", rd(0)); end
        checks++; if (bus.RD_busy[0] !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", bus.RD_busy[0]); end
    endtask

    task automatic test_dual_write();
        bus.WE3 = 1'b1; bus.AD3 = 5'd10; bus.WD3 = 32'h11;
        bus.WE4 = 1'b1; bus.AD4 = 5'd10; bus.WD4 = 32'h22;
        set_rd(0, 5'd10);
        tick();
        idle();
        checks++; if (bus.a0 !== 32'h22) begin errors++; $display("FAIL dual_same_a0: got %h expected %h", bus.a0, 32'h22); end
        checks++; if (rd(0) !== 32'h22) begin errors++; $display("FAIL dual_same_rd: got %h expected %h", rd(0), 32'h22); end

        bus.WE3 = 1'b1; bus.AD3 = 5'd11; bus.WD3 = 32'h33;
        bus.WE4 = 1'b1; bus.AD4 = 5'd17; bus.WD4 = 32'h44;
        set_rd(1, 5'd11);
        set_rd(2, 5'd17);
        tick();
        idle();
        checks++; if (bus.a1 !== 32'h33) begin errors++; $display("FAIL dual_diff_a1: got %h expected %h", bus.a1, 32'h33); end
        checks++; if (bus.a7 !== 32'h44) begin errors++; $display("FAIL dual_diff_a7: got %h expected %h", bus.a7, 32'h44); end
        checks++; if (bus.a0 !== 32'h22) begin errors++; $display("FAIL dual_diff_a0_kept: got %h expected %h", bus.a0, 32'h22); end
        checks++; if (rd(1) !== 32'h33) begin errors++; $display("FAIL dual_diff_rd1: got %h expected %h", rd(1), 32'h33); end
        checks++; if (rd(2) !== 32'h44) begin errors++; $display("FAIL dual_diff_rd2: got %h expected %h", rd(2), 32'h44); end
    endtask

    task automatic test_scoreboard();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        set_rd(0, 5'd7);
        tick();
        idle();
        checks++; if (bus.RD_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_issue: got %b expected 1", bus.RD_busy[0]); end

        bus.WE3 = 1'b1; bus.AD3 = 5'd7; bus.WD3 = 32'h77;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        tick();
        idle();
        checks++; if (bus.RD_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_set_over_clear: got %b expected 1", bus.RD_busy[0]); end
        checks++; if (rd(0) !== 32'h77) begin errors++; $display("FAIL sb_data77: got %h expected %h", rd(0), 32'h77); end
        tick();
        checks++; if (bus.RD_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_hold: got %b expected 1", bus.RD_busy[0]); end

        bus.WE4 = 1'b1; bus.AD4 = 5'd7; bus.WD4 = 32'h99;
`ifdef REGFILE_BYPASS_EN
        #1;
        checks++; if (bus.RD_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_bypass_busy: got %b expected 0", bus.RD_busy[0]); end
        checks++; if (rd(0) !== 32'h99) begin errors++; $display("FAIL sb_bypass_data: got %h expected %h", rd(0), 32'h99); end
`else
        #1;
        checks++; if (bus.RD_busy[0] !== 1'b1) begin errors++; $display("FAIL sb_nobypass_busy: got %b expected 1", bus.RD_busy[0]); end
`endif
        tick();
        idle();
        checks++; if (bus.RD_busy[0] !== 1'b0) begin errors++; $display("FAIL sb_clear: got %b expected 0", bus.RD_busy[0]); end
        checks++; if (rd(0) !== 32'h99) begin errors++; $display("FAIL sb_data99: got %h expected %h", rd(0), 32'h99); end
    endtask

    task automatic test_bypass();
        bus.WE3 = 1'b1; bus.AD3 = 5'd8; bus.WD3 = 32'h1;
        tick();
        idle();
        set_rd(2, 5'd8);
        #1;
        checks++; if (rd(2) !== 32'h1) begin errors++; $display("FAIL byp_init: got %h expected %h", rd(2), 32'h1); end

        bus.WE3 = 1'b1; bus.AD3 = 5'd8; bus.WD3 = 32'hCAFE;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'hCAFE;
`else
        exp_d = 32'h1;
`endif
        checks++; if (rd(2) !== exp_d) begin errors++; $display("FAIL byp_same_cycle: got %h expected %h", rd(2), exp_d); end
        tick();
        idle();
        checks++; if (rd(2) !== 32'hCAFE) begin errors++; $display("FAIL byp_next_cycle: got %h expected %h", rd(2), 32'hCAFE); end

        bus.WE3 = 1'b1; bus.AD3 = 5'd8; bus.WD3 = 32'h1111;
        bus.WE4 = 1'b1; bus.AD4 = 5'd8; bus.WD4 = 32'h2222;
        #1;
`ifdef REGFILE_BYPASS_EN
        exp_d = 32'h2222;
`else
        exp_d = 32'hCAFE;
`endif
        checks++; if (rd(2) !== exp_d) begin errors++; $display("FAIL byp_prio_same_cycle: got %h expected %h", rd(2), exp_d); end
        tick();
        idle();
        checks++; if (rd(2) !== 32'h2222) begin errors++; $display("FAIL byp_prio_stored: got %h expected %h", rd(2), 32'h2222); end
    endtask

    task automatic test_four_ports();
        bus.WE3 = 1'b1; bus.AD3 = 5'd1; bus.WD3 = 32'h101;
        bus.WE4 = 1'b1; bus.AD4 = 5'd2; bus.WD4 = 32'h202;
        tick();
        bus.WE3 = 1'b1; bus.AD3 = 5'd3; bus.WD3 = 32'h303;
        bus.WE4 = 1'b1; bus.AD4 = 5'd4; bus.WD4 = 32'h404;
        tick();
        idle();
        set_rd(0, 5'd3);
        set_rd(1, 5'd1);
        set_rd(2, 5'd4);
        set_rd(3, 5'd2);
        #1;
        checks++; if (rd(0) !== 32'h303) begin errors++; $display("FAIL four_p0: got %h expected %h", rd(0), 32'h303); end
        checks++; if (rd(1) !== 32'h101) begin errors++; $display("FAIL four_p1: got %h expected %h", rd(1), 32'h101); end
        checks++; if (rd(2) !== 32'h404) begin errors++; $display("FAIL four_p2: got %h expected %h", rd(2), 32'h404); end
        checks++; if (rd(3) !== 32'h202) begin errors++; $display("FAIL four_p3: got %h expected %h", rd(3), 32'h202); end
        checks++; if (bus.RD_busy !== 4'b0000) begin errors++; $display("FAIL four_busy: got %b expected 0000", bus.RD_busy); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        bus.AD = '0;
        set_rd(0, 5'd5);
        set_rd(1, 5'd17);
        #1;
        checks++; if (bus.RD !== '0) begin errors++; $display("FAIL init_rd: got %h expected 0", bus.RD); end
        checks++; if (bus.RD_busy !== 4'b0000) begin errors++; $display("FAIL init_busy: got %b expected 0000", bus.RD_busy); end
        checks++; if (bus.a7 !== 32'h0) begin errors++; $display("FAIL init_a7: got %h expected 0", bus.a7); end
        #1;
        rst_n = 1'b1;

        test_reset();
        test_x0();
        test_dual_write();
        test_scoreboard();
        test_bypass();
        test_four_ports();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
